// File: rtl/wb_pack_writer.sv
// Writeback packer: reduces per-channel partial sums, shifts/ReLUs/saturates each result,
// packs BYTES results per channel into one BRAM word and writes all channels together.
//
// state   | meaning
// S_IDLE  | waiting for start; run parameters captured on start
// S_RUN   | accepting beats until num_words*BYTES have been taken
// S_DRAIN | beats done; waiting for the pipeline and the final write to clear
// S_DONE  | one-cycle done pulse, then back to idle
module wb_pack_writer #(
  parameter int NUM_CH    = 2,
  parameter int NUM_TERMS = 5,
  parameter int SUM_W     = 11,
  parameter int OUT_W     = 8,
  parameter int BYTES     = 8,
  parameter int ADDR_W    = 12
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [NUM_CH*ADDR_W-1:0]          base_addr_i,
  input  logic [ADDR_W-1:0]                 num_words_i,
  input  logic [3:0]                        shift_i,
  input  logic                              relu_en_i,
  input  logic                              sum_valid_i,
  output logic                              sum_ready_o,
  input  logic [NUM_CH*NUM_TERMS*SUM_W-1:0] sums_i,
  output logic                              we_o,
  output logic [NUM_CH*ADDR_W-1:0]          addr_o,
  output logic [NUM_CH*BYTES*OUT_W-1:0]     din_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int RED_W  = SUM_W + $clog2(NUM_TERMS);
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = ADDR_W + IDX_W;
  localparam int WORD_W = BYTES * OUT_W;
  localparam logic signed [RED_W-1:0] SAT_MAX = RED_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [RED_W-1:0] SAT_MIN = -SAT_MAX - RED_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 beats_left_q, beats_left_d;
  logic [NUM_CH*ADDR_W-1:0]         base_q;
  logic [3:0]                       shift_q;
  logic                             relu_q;
  logic [ADDR_W-1:0]                word_cnt_q;
  logic [IDX_W-1:0]                 idx_q;
  logic                             v0_q, v1_q, last_q, we_q;
  logic [NUM_CH*NUM_TERMS*SUM_W-1:0] s0_q;
  logic signed [RED_W-1:0]          red_d [NUM_CH];
  logic signed [RED_W-1:0]          red_q [NUM_CH];
  logic signed [RED_W-1:0]          shifted [NUM_CH];
  logic [OUT_W-1:0]                 lane_d [NUM_CH];
  logic [NUM_CH*WORD_W-1:0]         word_q;
  logic [NUM_CH*WORD_W-1:0]         din_q;
  logic [NUM_CH*ADDR_W-1:0]         addr_q;
  logic                             start_run, accept, pipe_empty;

  assign start_run  = (state_q == S_IDLE) && start_i;
  assign accept     = sum_valid_i && sum_ready_o;
  assign pipe_empty = !v0_q && !v1_q && !last_q;

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    sum_ready_o  = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_RUN;
          beats_left_d = CNT_W'(num_words_i) * CNT_W'(BYTES);
        end
      end
      S_RUN: begin
        busy_o      = 1'b1;
        sum_ready_o = (beats_left_q != '0);
        if (sum_valid_i && (beats_left_q != '0))
          beats_left_d = beats_left_q - CNT_W'(1);
        if (beats_left_q == '0)
          state_d = pipe_empty ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (pipe_empty) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Reduction width is grown so the sum of NUM_TERMS sign-extended terms cannot overflow.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      red_d[c] = '0;
      for (int t = 0; t < NUM_TERMS; t++)
        red_d[c] = red_d[c] + RED_W'(signed'(s0_q[(c*NUM_TERMS+t)*SUM_W +: SUM_W]));
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      shifted[c] = red_q[c] >>> shift_q;
      if (relu_q && shifted[c][RED_W-1]) shifted[c] = '0;
      if (shifted[c] > SAT_MAX)      lane_d[c] = SAT_MAX[OUT_W-1:0];
      else if (shifted[c] < SAT_MIN) lane_d[c] = SAT_MIN[OUT_W-1:0];
      else                           lane_d[c] = shifted[c][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      beats_left_q <= '0;
      base_q       <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      word_cnt_q   <= '0;
      idx_q        <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      last_q       <= 1'b0;
      we_q         <= 1'b0;
      s0_q         <= '0;
      red_q        <= '{default: '0};
      word_q       <= '0;
      din_q        <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      if (start_run) begin
        base_q     <= base_addr_i;
        shift_q    <= shift_i;
        relu_q     <= relu_en_i;
        word_cnt_q <= '0;
        idx_q      <= '0;
      end
      v0_q <= accept;
      if (accept) s0_q <= sums_i;
      v1_q  <= v0_q;
      red_q <= red_d;
      last_q <= 1'b0;
      if (v1_q) begin
        for (int c = 0; c < NUM_CH; c++)
          word_q[c*WORD_W + int'(idx_q)*OUT_W +: OUT_W] <= lane_d[c];
        last_q <= (idx_q == IDX_W'(BYTES - 1));
        idx_q  <= (idx_q == IDX_W'(BYTES - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      // word_q already holds every lane of the finished word when last_q is seen
      we_q <= last_q;
      if (last_q) begin
        din_q <= word_q;
        for (int c = 0; c < NUM_CH; c++)
          addr_q[c*ADDR_W +: ADDR_W] <= base_q[c*ADDR_W +: ADDR_W] + word_cnt_q;
        word_cnt_q <= word_cnt_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_pack_writer.sv
// Scoreboard bench for wb_pack_writer: expected words come from an arithmetic model of the
// reduce/shift/ReLU/saturate rules and are checked by a monitor whenever we is high.
module tb_wb_pack_writer;
  localparam int NUM_CH = 2, NUM_TERMS = 5, SUM_W = 11, OUT_W = 8, BYTES = 8, ADDR_W = 12;
  localparam int SW = NUM_CH*NUM_TERMS*SUM_W;
  localparam int AW = NUM_CH*ADDR_W;
  localparam int DW = NUM_CH*BYTES*OUT_W;

  typedef int terms_t [NUM_TERMS];
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] din; } exp_t;

  logic clk = 1'b0;
  logic rst_i, start_i, relu_en_i, sum_valid_i, sum_ready_o, we_o, busy_o, done_o;
  logic [AW-1:0] base_addr_i, addr_o;
  logic [ADDR_W-1:0] num_words_i;
  logic [3:0] shift_i;
  logic [SW-1:0] sums_i;
  logic [DW-1:0] din_o;

  wb_pack_writer #(.NUM_CH(NUM_CH), .NUM_TERMS(NUM_TERMS), .SUM_W(SUM_W), .OUT_W(OUT_W),
                   .BYTES(BYTES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
    .sum_valid_i(sum_valid_i), .sum_ready_o(sum_ready_o), .sums_i(sums_i),
    .we_o(we_o), .addr_o(addr_o), .din_o(din_o), .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0;
  int we_cnt = 0, last_we_cyc = -1, done_cyc = -1, done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (we_o) begin
      we_cnt++;
      last_we_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we addr=%0h din=%0h required no write", addr_o, din_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (addr_o !== mon_e.addr || din_o !== mon_e.din) begin
          errors++;
          $display("FAIL word addr=%0h din=%0h required addr=%0h din=%0h",
                   addr_o, din_o, mon_e.addr, mon_e.din);
        end
      end
    end
    if (done_o) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL busy_during_done got=%0b required=0", busy_o);
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  // Floor shift, optional ReLU, saturation to signed OUT_W.
  function automatic logic [OUT_W-1:0] ref_lane(input int s, input int sh, input bit relu);
    int v;
    v = s >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[OUT_W-1:0];
  endfunction

  task automatic run(input logic [ADDR_W-1:0] b0, input logic [ADDR_W-1:0] b1, input int nw,
                     input int sh, input bit relu, input bit rnd, input terms_t tv,
                     input int gap_max, input int abort_at, input bit poke_start);
    logic [SW-1:0] beats[$];
    logic [SW-1:0] v;
    exp_t e;
    int s, t, tmo, np;
    np = 0;
    for (int w = 0; w < nw; w++) begin
      e.din = '0;
      e.addr[0 +: ADDR_W]      = b0 + ADDR_W'(w);
      e.addr[ADDR_W +: ADDR_W] = b1 + ADDR_W'(w);
      for (int b = 0; b < BYTES; b++) begin
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          s = 0;
          for (int k = 0; k < NUM_TERMS; k++) begin
            t = rnd ? int'($urandom_range(0, 2047)) - 1024 : tv[k];
            s += t;
            v[(c*NUM_TERMS+k)*SUM_W +: SUM_W] = t[SUM_W-1:0];
          end
          e.din[(c*BYTES+b)*OUT_W +: OUT_W] = ref_lane(s, sh, relu);
        end
        beats.push_back(v);
      end
      if (abort_at < 0 || (w+1)*BYTES <= abort_at) begin
        exp_q.push_back(e);
        np++;
      end
    end

    we_cnt = 0; done_cyc = -1; last_we_cyc = -1; done_cnt = 0;
    base_addr_i = {b1, b0}; num_words_i = ADDR_W'(nw); shift_i = 4'(sh); relu_en_i = relu;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    base_addr_i = AW'($urandom); num_words_i = ADDR_W'($urandom);
    shift_i = 4'($urandom); relu_en_i = ~relu;
    chk("busy_after_start", busy_o, 1);

    for (int i = 0; i < nw*BYTES; i++) begin
      if (i == abort_at) break;
      repeat ($urandom_range(0, gap_max)) begin
        sum_valid_i = 1'b0; sums_i = SW'($urandom);
        @(posedge clk); #1;
      end
      sum_valid_i = 1'b1; sums_i = beats[i];
      if (poke_start && i == 2) start_i = 1'b1;
      tmo = 0;
      while (!sum_ready_o && tmo < 50) begin @(posedge clk); #1; tmo++; end
      if (tmo >= 50) begin
        chk("ready_timeout", tmo, 0);
        break;
      end
      @(posedge clk); #1;
      start_i = 1'b0; sum_valid_i = 1'b0;
    end

    if (abort_at >= 0) begin
      rst_i = 1'b1;
      @(posedge clk); #1;
      chk("rst_ctrl_outs", {we_o, busy_o, done_o, sum_ready_o}, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_din", din_o, 0);
      rst_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_we_count", we_cnt, np);
      chk("abort_queue_empty", exp_q.size(), 0);
      return;
    end

    chk("ready_low_after_last", sum_ready_o, 0);
    sum_valid_i = 1'b1;
    repeat (2) begin sums_i = SW'($urandom); @(posedge clk); #1; end
    sum_valid_i = 1'b0;
    tmo = 0;
    while (done_cyc < 0 && tmo < 200) begin @(posedge clk); #1; tmo++; end
    chk("done_seen", done_cyc >= 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_width", done_cnt, 1);
    chk("we_count", we_cnt, nw);
    if (nw > 0) chk("done_after_we", done_cyc, last_we_cyc + 1);
    chk("idle_busy", busy_o, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0; shift_i = '0;
    relu_en_i = 1'b0; sum_valid_i = 1'b0; sums_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outs", {we_o, busy_o, done_o, sum_ready_o}, 0);
    chk("reset_addr", addr_o, 0);
    chk("reset_din", din_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    run(12'd0, 12'd32, 1, 0, 0, 0, '{1, 1, 1, 1, 1}, 0, -1, 0);
    run(12'd5, 12'd9, 1, 0, 0, 0, '{200, 200, 200, 200, 200}, 0, -1, 0);
    run(12'd5, 12'd9, 1, 0, 0, 0, '{-200, -200, -200, -200, -200}, 1, -1, 0);
    run(12'd5, 12'd9, 1, 0, 1, 0, '{-200, -200, -200, -200, -200}, 1, -1, 0);
    run(12'd1, 12'd2, 1, 3, 0, 0, '{16, 16, 16, 16, 16}, 0, -1, 0);
    run(12'd1, 12'd2, 1, 3, 0, 0, '{-16, -16, -16, -16, -17}, 0, -1, 0);
    run(12'd100, 12'd200, 4, 2, 0, 1, '{0, 0, 0, 0, 0}, 0, -1, 0);
    run(12'd100, 12'd200, 4, 2, 1, 1, '{0, 0, 0, 0, 0}, 3, -1, 1);
    run(12'hFFF, 12'hFFF, 2, 0, 0, 1, '{0, 0, 0, 0, 0}, 1, -1, 0);
    run(12'd7, 12'd8, 0, 0, 0, 0, '{0, 0, 0, 0, 0}, 0, -1, 0);
    run(12'd40, 12'd80, 2, 1, 0, 1, '{0, 0, 0, 0, 0}, 2, 12, 0);
    run(12'd40, 12'd80, 1, 1, 0, 1, '{0, 0, 0, 0, 0}, 0, -1, 0);
    for (int r = 0; r < 6; r++)
      run(ADDR_W'($urandom), ADDR_W'($urandom), $urandom_range(1, 3), $urandom_range(0, 15),
          1'($urandom), 1, '{0, 0, 0, 0, 0}, $urandom_range(0, 3), -1, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
